cobertura_ctrl: RTL
===================

// Module: cobertura_ctrl
// PURPOSE
//  Sequential motor controller for the retractable roof (cobertura). Replaces the purely
//  combinational open/close decode with a clocked FSM. Filters the light (L) and rain (U)
//  sensors, drives the open (A) and close (F) motor outputs, and stops at the limit switches
//  (Fe = fully open, Fd = fully closed). Enforces dead-time on reversal, run timeout and fault latch.
// PARAMETERS
//  DEB_CYC      4    cycles L/U must stay stable (after sync) before the filtered value changes
//  DEAD_CYC     8    cycles both motor outputs held 0 on PAUSA (reversal/fault recovery)
//  TIMEOUT_CYC  100  max cycles in ABRINDO/FECHANDO without reaching the limit -> FALHA
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  L          in   1  light sensor, async raw (1 = daylight)
//  U          in   1  rain sensor, async raw (1 = raining)
//  Fe         in   1  limit switch fully open, async raw (1 = at limit)
//  Fd         in   1  limit switch fully closed, async raw (1 = at limit)
//  clr_falha  in   1  sync fault clear, 1-cycle pulse
//  A          out  1  motor open command, registered
//  F          out  1  motor close command, registered
//  falha      out  1  fault flag, registered
//  estado     out  3  FSM state: 0 IDLE, 1 ABRINDO, 2 FECHANDO, 3 PAUSA, 4 FALHA
// BEHAVIOUR
//  Reset (async, rst_n=0): A=0, F=0, falha=0, estado=IDLE, sync flops=0, filtered L/U=0, counters=0.
//  Sync: all four inputs pass a 2-flop synchronizer; Fe/Fd are used after sync only (no debounce).
//  Debounce: filtered Lf/Uf take the synced value once it has differed from them for DEB_CYC
//   consecutive cycles; any mismatch gap restarts the count. Raw edge -> Lf/Uf = 2+DEB_CYC cycles.
//  Target: alvo_abrir = Lf & ~Uf. Rain always forces close; night (Lf=0) forces close.
//  FSM (one transition per clock; A/F/falha are registered decodes of the next state):
//   IDLE:     alvo_abrir & ~Fe -> ABRINDO; ~alvo_abrir & ~Fd -> FECHANDO; else stay.
//   ABRINDO:  A=1. Fe -> IDLE. ~alvo_abrir -> PAUSA. run counter == TIMEOUT_CYC-1 -> FALHA.
//   FECHANDO: F=1. Fd -> IDLE. alvo_abrir -> PAUSA. run counter == TIMEOUT_CYC-1 -> FALHA.
//   PAUSA:    A=F=0 for exactly DEAD_CYC cycles, then IDLE (IDLE re-evaluates the target).
//   FALHA:    A=F=0, falha=1; leaves only on clr_falha -> PAUSA (falha=0 on exit).
//  Priority per cycle: Fe&Fd both 1 (synced) -> FALHA from any state > limit reached > target
//   change > timeout. clr_falha is ignored while Fe&Fd persist (FALHA re-entered/held).
//  Run counter clears on entry to ABRINDO/FECHANDO; dead-time counter clears on entry to PAUSA.
//  Invariant: A & F never both 1 in any cycle; a reversal always passes through PAUSA.
//  Reset mid-motion: outputs drop to 0 asynchronously; after release the FSM restarts from IDLE
//   with Lf=Uf=0 (target close), i.e. closes unless Fd is already active.
// TESTING (DEB_CYC=4, DEAD_CYC=8, TIMEOUT_CYC=100)
//  1 Reset release with Fd=1, L=U=0 -> stays IDLE, A=F=0, falha=0 indefinitely.
//  2 Fd=1, set L=1 -> A=1 starting within 2+4+2 cycles; assert Fe=1, Fd=0 -> A=0 within 3 cycles, IDLE.
//  3 While ABRINDO, pulse L=0 for 3 cycles -> no change (debounce); raise U=1 steady ->
//     A=0, PAUSA for 8 cycles with A=F=0, then F=1; never A&F=1.
//  4 FECHANDO with Fd held 0 for 100 cycles -> FALHA, F=0, falha=1, estado=4; clr_falha ->
//     PAUSA 8 cycles -> resumes F=1.
//  5 Fe=Fd=1 while IDLE -> FALHA within 3 cycles; clr_falha with both still 1 -> stays FALHA.
//  6 rst_n=0 mid-ABRINDO -> A=0 immediately (async); after release, closes (F=1) with L=U=0.

Source files
------------

// File: rtl/cobertura_ctrl.sv
// Retractable roof motor controller: synchronises and debounces the light/rain sensors and
// runs the open/close motor FSM with limit stops, reversal dead-time, run timeout and fault latch.
module cobertura_ctrl #(
  parameter int DEB_CYC     = 4,
  parameter int DEAD_CYC    = 8,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       L,
  input  logic       U,
  input  logic       Fe,
  input  logic       Fd,
  input  logic       clr_falha,
  output logic       A,
  output logic       F,
  output logic       falha,
  output logic [2:0] estado
);

  localparam int DEB_W  = (DEB_CYC > 1)     ? $clog2(DEB_CYC)     : 1;
  localparam int DEAD_W = (DEAD_CYC > 1)    ? $clog2(DEAD_CYC)    : 1;
  localparam int RUN_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ABRINDO  = 3'd1,
    FECHANDO = 3'd2,
    PAUSA    = 3'd3,
    FALHA    = 3'd4
  } state_e;

  // Bit order of the synchroniser: {Fd, Fe, U, L}
  logic [3:0] sync1_q, sync2_q;
  logic [1:0] warm_q;
  logic [1:0] filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= {Fd, Fe, U, L};
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
    end
  end

  // Debounce L (gi=0) and U (gi=1): filtered value follows after DEB_CYC consecutive mismatches
  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic             filt_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else if (sync2_q[gi] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
        filt_q <= sync2_q[gi];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign filt[gi] = filt_q;
  end

  logic fe_s, fd_s, alvo_abrir, ready;
  assign fe_s       = sync2_q[2];
  assign fd_s       = sync2_q[3];
  assign alvo_abrir = filt[0] & ~filt[1];
  // Hold IDLE until the synchronisers carry real input values, not their reset zeros
  assign ready      = warm_q[1];

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic                a_q, f_q, falha_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      dead_cnt_q <= '0;
      a_q        <= 1'b0;
      f_q        <= 1'b0;
      falha_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      a_q        <= (state_d == ABRINDO);
      f_q        <= (state_d == FECHANDO);
      falha_q    <= (state_d == FALHA);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ready) begin
      state_d = IDLE;
    end else if (fe_s && fd_s) begin
      state_d = FALHA;
    end else begin
      case (state_q)
        IDLE: begin
          if (alvo_abrir && !fe_s)       state_d = ABRINDO;
          else if (!alvo_abrir && !fd_s) state_d = FECHANDO;
        end
        ABRINDO: begin
          if (fe_s)                                         state_d = IDLE;
          else if (!alvo_abrir)                             state_d = PAUSA;
          else if (run_cnt_q == RUN_W'(TIMEOUT_CYC - 1))    state_d = FALHA;
        end
        FECHANDO: begin
          if (fd_s)                                         state_d = IDLE;
          else if (alvo_abrir)                              state_d = PAUSA;
          else if (run_cnt_q == RUN_W'(TIMEOUT_CYC - 1))    state_d = FALHA;
        end
        PAUSA: begin
          if (dead_cnt_q == DEAD_W'(DEAD_CYC - 1)) state_d = IDLE;
        end
        FALHA: begin
          if (clr_falha) state_d = PAUSA;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters restart on every state entry and only advance while the state is held
  always_comb begin
    run_cnt_d  = '0;
    dead_cnt_d = '0;
    if (state_d == state_q && (state_q == ABRINDO || state_q == FECHANDO))
      run_cnt_d = run_cnt_q + 1'b1;
    if (state_d == state_q && state_q == PAUSA)
      dead_cnt_d = dead_cnt_q + 1'b1;
  end

  assign A      = a_q;
  assign F      = f_q;
  assign falha  = falha_q;
  assign estado = state_q;

endmodule
